// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-channel bit-interleaved TDM serial link.
// Slots run ch0, ch1, ch2, ch3 and repeat. Each channel word is WIDTH bits, sent
// MSB first, one bit per slot. A frame marker flags ch0's first bit. Every
// completed word is presented on a registered output together with a one-cycle
// vld strobe.
// Optional build macro: MISSED_FRAME_EN. When it is defined, a missing frame
// marker at the expected boundary drops the link back to HUNT. When it is not
// defined, the receiver flywheels through the missing marker.
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             frame,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       vld,
    output logic             locked,
    output logic             sync_err
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state_reg;
    logic [1:0]    slot_reg;
    logic [BW-1:0] bitcnt_reg;
    logic          sync_err_reg;

    logic          boundary;
    logic          hunt_lock;
    logic          misalign;
    logic          missed;
    logic          restart;
    logic          flush;
    logic          advance;

    logic [WIDTH-1:0] ch_bus [4];

    // Decode this edge's sample into control events. A misaligned frame beats a
    // word completion, so a partial word is never published.
    always_comb begin
        boundary  = (slot_reg == 2'd0) && (bitcnt_reg == '0);
        hunt_lock = en && (state_reg == HUNT) && frame;
        misalign  = en && (state_reg == LOCKED) && frame && !boundary;
`ifdef MISSED_FRAME_EN
        missed    = en && (state_reg == LOCKED) && !frame && boundary;
`else
        missed    = 1'b0;
`endif
        // The restarting sample is itself ch0's first bit.
        restart   = hunt_lock || misalign;
        flush     = restart || missed;
        advance   = en && (state_reg == LOCKED) && !misalign && !missed;
    end

    // Frame state, slot/bit counters and the error strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            slot_reg     <= 2'd0;
            bitcnt_reg   <= '0;
            sync_err_reg <= 1'b0;
        end else begin
            sync_err_reg <= misalign || missed;
            if (restart) begin
                state_reg  <= LOCKED;
                slot_reg   <= 2'd1;
                bitcnt_reg <= '0;
            end else if (missed) begin
                state_reg  <= HUNT;
                slot_reg   <= 2'd0;
                bitcnt_reg <= '0;
            end else if (advance) begin
                slot_reg <= slot_reg + 2'd1;
                if (slot_reg == 2'd3) begin
                    bitcnt_reg <= (bitcnt_reg == LAST) ? '0 : bitcnt_reg + 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] acc_reg;
            logic [WIDTH-1:0] out_reg;
            logic             vld_reg;
            logic             shift;
            logic             complete;

            assign shift    = advance && (slot_reg == 2'(gi));
            assign complete = shift && (bitcnt_reg == LAST);

            // Per-channel shift accumulator and output word. The completed word
            // is taken straight from the accumulator plus the incoming bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                    out_reg <= '0;
                    vld_reg <= 1'b0;
                end else begin
                    vld_reg <= complete;
                    if (flush) begin
                        acc_reg <= (gi == 0 && restart) ? {{(WIDTH-1){1'b0}}, din} : '0;
                    end else if (shift) begin
                        acc_reg <= {acc_reg[WIDTH-2:0], din};
                    end
                    if (complete) begin
                        out_reg <= {acc_reg[WIDTH-2:0], din};
                    end
                end
            end

            assign ch_bus[gi] = out_reg;
            assign vld[gi]    = vld_reg;
        end
    endgenerate

    assign ch0      = ch_bus[0];
    assign ch1      = ch_bus[1];
    assign ch2      = ch_bus[2];
    assign ch3      = ch_bus[3];
    assign locked   = (state_reg == LOCKED);
    assign sync_err = sync_err_reg;

endmodule
